uart_tx_sched: RTL and testbench

Transmit-side scheduler and bit sequencer for the UART block. It arbitrates round-robin among `NUM_REQ` byte requesters and latches the winning byte into a transmit holding/shift register. It then sequences that register through the start, data and stop phases at the baud rate derived from `clk`, honouring the receiver's clear-to-send. It sits between the byte producers (command/status engines) and the serial `tx` pin.

---
 rtl/uart_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/uart_tx_sched.sv | 154 +++++++++++++++
 tb/tb_uart_tx_sched.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first pending request at or after
// ptr (wrapping) wins. Produces a one-hot grant, its index and an any flag.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 any
);

  localparam int IW = $clog2(N);

  // Scan upward from ptr with wrap and keep only the first hit.
  always_comb begin
    logic [IW-1:0] idx;
    logic [IW-1:0] id_v;
    logic          hit;
    logic          found;
    gnt   = '0;
    idx   = '0;
    id_v  = '0;
    hit   = 1'b0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx      = IW'((int'(ptr) + i) % N);
      hit      = !found && req[idx];
      gnt[idx] = hit;
      id_v     = hit ? idx : id_v;
      found    = found | hit;
    end
    gnt_id = id_v;
    any    = found;
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Transmit scheduler: picks a requester round-robin, latches its byte and
// shifts it out as start bit, 8 data bits (LSB first) and 1 or 2 stop bits.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       cts,
  output logic                       tx,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       frame_done
);

  localparam int IW    = $clog2(NUM_REQ);
  localparam int BW_B  = $clog2(CLKS_PER_BIT);
  localparam int BW_S  = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam int BW    = (BW_S > BW_B) ? BW_S : BW_B;

  localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_REQ  = IW'(NUM_REQ - 1);

  tx_state_t     r_state,    w_state_nxt;
  logic [BW-1:0] r_baud,     w_baud_nxt;
  logic [2:0]    r_bit_cnt,  w_bit_cnt_nxt;
  logic [7:0]    r_shreg,    w_shreg_nxt;
  logic [IW-1:0] r_rr_ptr,   w_rr_ptr_nxt;
  logic [IW-1:0] r_grant_id, w_grant_id_nxt;

  logic [NUM_REQ-1:0] w_gnt;
  logic [IW-1:0]      w_gnt_id;
  logic               w_any;
  logic               w_accept;
  logic [7:0]         w_bytes [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign w_bytes[g] = req_data[8*g +: 8];
  end

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req    (req_valid),
    .ptr    (r_rr_ptr),
    .gnt    (w_gnt),
    .gnt_id (w_gnt_id),
    .any    (w_any)
  );

  // Acceptance only in IDLE with cts; reset suppresses the strobe.
  assign w_accept  = (r_state == IDLE) && cts && w_any && !reset;
  assign req_ready = w_accept ? w_gnt : '0;

  // Next-state, baud/bit counters and shift register update.
  always_comb begin
    w_state_nxt    = r_state;
    w_baud_nxt     = r_baud + 1'b1;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_shreg_nxt    = r_shreg;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_grant_id_nxt = r_grant_id;
    case (r_state)
      IDLE: begin
        w_baud_nxt = '0;
        if (w_accept) begin
          w_state_nxt    = START;
          w_shreg_nxt    = w_bytes[w_gnt_id];
          w_grant_id_nxt = w_gnt_id;
          w_rr_ptr_nxt   = (w_gnt_id == LAST_REQ) ? '0 : (w_gnt_id + 1'b1);
        end else begin
          w_state_nxt = IDLE;
        end
      end
      START: begin
        if (r_baud == BIT_LAST) begin
          w_state_nxt   = DATA;
          w_baud_nxt    = '0;
          w_bit_cnt_nxt = 3'd0;
        end else begin
          w_state_nxt = START;
        end
      end
      DATA: begin
        if (r_baud == BIT_LAST) begin
          w_baud_nxt    = '0;
          w_shreg_nxt   = {1'b0, r_shreg[7:1]};
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == LAST_BIT) begin
            w_state_nxt = STOP;
          end else begin
            w_state_nxt = DATA;
          end
        end else begin
          w_state_nxt = DATA;
        end
      end
      STOP: begin
        if (r_baud == STOP_LAST) begin
          w_state_nxt = IDLE;
          w_baud_nxt  = '0;
        end else begin
          w_state_nxt = STOP;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_baud_nxt  = '0;
      end
    endcase
  end

  // State and datapath registers; reset drops any partial frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_baud     <= '0;
      r_bit_cnt  <= 3'd0;
      r_shreg    <= 8'h00;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_baud     <= w_baud_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_shreg    <= w_shreg_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_grant_id <= w_grant_id_nxt;
    end
  end

  // Serial line level decoded from the registered state.
  always_comb begin
    tx = UART_IDLE_LEVEL;
    case (r_state)
      IDLE:    tx = UART_IDLE_LEVEL;
      START:   tx = 1'b0;
      DATA:    tx = r_shreg[0];
      STOP:    tx = UART_IDLE_LEVEL;
      default: tx = UART_IDLE_LEVEL;
    endcase
  end

  assign busy       = (r_state != IDLE);
  assign frame_done = (r_state == STOP) && (r_baud == STOP_LAST);
  assign grant_id   = r_grant_id;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench: two instances (C=4 with one and two stop bits). Stimulus
// pushes expected grants; a negedge monitor checks acceptances and frames.
module tb_uart_tx_sched;

  typedef struct {
    int         idx;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [3:0]  rv    [2];
  logic [31:0] rd    [2];
  logic        cts_v [2];
  logic [7:0]  rr_w;
  logic [1:0]  tx_w;
  logic [1:0]  busy_w;
  logic [1:0]  fd_w;
  logic [3:0]  gid_w;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  int         act     [2];
  int         nn      [2];
  int         ff      [2];
  logic [7:0] eb      [2];
  int         eid     [2];
  int         last_id [2];

  uart_tx_sched #(.NUM_REQ(4), .CLKS_PER_BIT(4), .STOP_BITS(1)) u_dut0 (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (rv[0]),
    .req_data   (rd[0]),
    .req_ready  (rr_w[3:0]),
    .cts        (cts_v[0]),
    .tx         (tx_w[0]),
    .busy       (busy_w[0]),
    .grant_id   (gid_w[1:0]),
    .frame_done (fd_w[0])
  );

  uart_tx_sched #(.NUM_REQ(4), .CLKS_PER_BIT(4), .STOP_BITS(2)) u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (rv[1]),
    .req_data   (rd[1]),
    .req_ready  (rr_w[7:4]),
    .cts        (cts_v[1]),
    .tx         (tx_w[1]),
    .busy       (busy_w[1]),
    .grant_id   (gid_w[3:2]),
    .frame_done (fd_w[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, a, e);
    end
  endtask

  // Expected line level in frame cycle n (C=4): start 1..4, data 5..36, stop after.
  function automatic logic exp_tx(input int n, input logic [7:0] b);
    if (n <= 4) return 1'b0;
    else if (n <= 36) return b[3'((n - 5) / 4)];
    else return 1'b1;
  endfunction

  task automatic push(input int d, input int idx, input logic [7:0] data, input int c);
    exp_t e;
    e.idx = idx; e.data = data; e.cyc = c;
    if (d == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
  endtask

  task automatic mon(input int d);
    exp_t       e;
    logic       have;
    logic [3:0] rdy;
    rdy = rr_w[4*d +: 4];
    if (act[d] != 0) begin
      nn[d]++;
      chk("tx", 32'(tx_w[d]), 32'(exp_tx(nn[d], eb[d])));
      chk("busy", 32'(busy_w[d]), 32'd1);
      chk("frame_done", 32'(fd_w[d]), 32'(nn[d] == ff[d]));
      chk("ready_in_frame", 32'(rdy), 32'd0);
      if (nn[d] == 1 || nn[d] == ff[d]) chk("grant_id", 32'(gid_w[2*d +: 2]), 32'(eid[d]));
      if (nn[d] == ff[d]) act[d] = 0;
    end else begin
      chk("idle_tx", 32'(tx_w[d]), 32'd1);
      chk("idle_busy", 32'(busy_w[d]), 32'd0);
      chk("idle_frame_done", 32'(fd_w[d]), 32'd0);
      chk("idle_grant_id", 32'(gid_w[2*d +: 2]), 32'(last_id[d]));
      if (rdy != 4'd0) begin
        have = 1'b0;
        if (d == 0) begin
          if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
        end else begin
          if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
        end
        if (!have) begin
          chk("unexpected_accept", 32'(rdy), 32'd0);
        end else begin
          chk("ready_onehot", 32'(rdy), 32'(4'b0001 << e.idx));
          chk("accept_cycle", 32'(cyc), 32'(e.cyc));
          act[d]     = 1;
          nn[d]      = 0;
          eb[d]      = e.data;
          eid[d]     = e.idx;
          last_id[d] = e.idx;
        end
      end
    end
    if (reset) begin
      chk("ready_in_reset", 32'(rdy), 32'd0);
      act[d]     = 0;
      last_id[d] = 0;
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) mon(d);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic setb(input int d, input int i, input logic [7:0] b);
    rd[d][8*i +: 8] = b;
  endtask

  initial begin
    ff[0] = 40; ff[1] = 44;
    for (int d = 0; d < 2; d++) begin
      act[d] = 0; nn[d] = 0; eb[d] = 8'h00; eid[d] = 0; last_id[d] = 0;
      rv[d] = 4'd0; rd[d] = 32'd0; cts_v[d] = 1'b0;
    end
    reset = 1'b1;
    tick(3);
    reset = 1'b0;

    // Single byte 0xCD from requester 0.
    cts_v[0] = 1'b1;
    setb(0, 0, 8'hCD);
    rv[0] = 4'b0001;
    push(0, 0, 8'hCD, cyc);
    tick(1); rv[0] = 4'b0000;
    tick(45);

    // Fresh pointer, all four valid: order 0,1,2,3,0 spaced 41 cycles.
    reset = 1'b1; tick(2); reset = 1'b0;
    setb(0, 0, 8'hA5); setb(0, 1, 8'h3C); setb(0, 2, 8'h0F); setb(0, 3, 8'h81);
    rv[0] = 4'b1111;
    push(0, 0, 8'hA5, cyc);
    push(0, 1, 8'h3C, cyc + 41);
    push(0, 2, 8'h0F, cyc + 82);
    push(0, 3, 8'h81, cyc + 123);
    push(0, 0, 8'hA5, cyc + 164);
    tick(165); rv[0] = 4'b0000;
    tick(40);

    // cts low holds off a pending request; raising it accepts at once;
    // dropping it mid-frame does not disturb the frame.
    cts_v[0] = 1'b0;
    setb(0, 2, 8'h5A);
    rv[0] = 4'b0100;
    tick(6);
    cts_v[0] = 1'b1;
    push(0, 2, 8'h5A, cyc);
    tick(1); rv[0] = 4'b0000;
    tick(9); cts_v[0] = 1'b0;
    tick(35); cts_v[0] = 1'b1;

    // Reset at cycle 15 of a frame from requester 1; pointer returns to 0.
    setb(0, 1, 8'hE7);
    rv[0] = 4'b0010;
    push(0, 1, 8'hE7, cyc);
    tick(1); rv[0] = 4'b0000;
    tick(14); reset = 1'b1;
    tick(1); reset = 1'b0;
    setb(0, 2, 8'h6C);
    rv[0] = 4'b0110;
    push(0, 1, 8'hE7, cyc);
    push(0, 2, 8'h6C, cyc + 41);
    tick(42); rv[0] = 4'b0000;
    tick(40);

    // Requester 1 pulses valid while 3 is served: no grant, pointer stays 0.
    setb(0, 3, 8'h42);
    rv[0] = 4'b1000;
    push(0, 3, 8'h42, cyc);
    tick(1); rv[0] = 4'b0000;
    tick(5); rv[0] = 4'b0010;
    tick(5); rv[0] = 4'b0000;
    tick(35);
    rv[0] = 4'b1010;
    push(0, 1, 8'hE7, cyc);
    tick(1); rv[0] = 4'b0000;
    tick(45);

    // Two stop bits: frame_done at 44, next acceptance at 45.
    cts_v[1] = 1'b1;
    setb(1, 0, 8'h3A); setb(1, 1, 8'hC5);
    rv[1] = 4'b0011;
    push(1, 0, 8'h3A, cyc);
    push(1, 1, 8'hC5, cyc + 45);
    tick(46); rv[1] = 4'b0000;
    tick(45);

    chk("sb_drain0", 32'(exp_q0.size()), 32'd0);
    chk("sb_drain1", 32'(exp_q1.size()), 32'd0);
    chk("frame_open0", 32'(act[0]), 32'd0);
    chk("frame_open1", 32'(act[1]), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
